// File: rtl/eval_scheduler.sv
// Shares one STAGES-deep evaluation pipeline between queue-driven (A) and periodic (B) evals.
// Optional macro SCHED_OVERRUN_CNT_EN adds the saturating overrun_cnt port and counter.
module eval_scheduler #(
  parameter int PERIOD_CYCLES = 10,
  parameter int STAGES        = 3,
  parameter int TIMER_W       = 16,
  parameter int STAGE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               q_pop_valid,
  output logic               q_pop,
  output logic               en_a,
  output logic               en_b,
  output logic [STAGE_W-1:0] stage,
  output logic               win_rotate,
  output logic [TIMER_W-1:0] timer_b,
  output logic               busy,
  output logic               overrun
`ifdef SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]        overrun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, POP, EVAL_A, EVAL_B} state_t;

  localparam logic [TIMER_W-1:0] LAST_TIMER = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);
  localparam logic [STAGE_W-1:0] IDLE_STAGE = STAGE_W'(STAGES);

  state_t             state_reg, state_next;
  logic [STAGE_W-1:0] stage_reg, stage_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               pending_reg, pending_next;
  logic               overrun_reg, overrun_next;
  logic               deadline;
  logic               consume;
  logic               lost;

  always_comb begin
    deadline     = en && (timer_reg == LAST_TIMER);
    timer_next   = timer_reg;
    state_next   = state_reg;
    stage_next   = stage_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    consume      = 1'b0;
    lost         = 1'b0;

    if (en) begin
      timer_next = deadline ? '0 : timer_reg + TIMER_W'(1);
      case (state_reg)
        IDLE: begin
          // A deadline arriving this very cycle counts as pending and wins over the queue.
          if (pending_reg || deadline) begin
            state_next = EVAL_B;
            stage_next = '0;
            consume    = 1'b1;
          end else if (q_pop_valid) begin
            state_next = POP;
          end
        end
        POP: begin
          state_next = EVAL_A;
          stage_next = '0;
        end
        EVAL_A, EVAL_B: begin
          if (stage_reg == LAST_STAGE) begin
            state_next = IDLE;
            stage_next = IDLE_STAGE;
          end else begin
            stage_next = stage_reg + STAGE_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Launching B consumes the old request; a coincident deadline becomes the next one.
    if (consume) begin
      pending_next = pending_reg && deadline;
    end else if (deadline) begin
      pending_next = 1'b1;
      lost         = pending_reg;
    end
    if (lost) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      stage_reg   <= IDLE_STAGE;
      timer_reg   <= '0;
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stage_reg   <= stage_next;
      timer_reg   <= timer_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_cnt_reg <= '0;
    end else if (lost && (overrun_cnt_reg != 16'hFFFF)) begin
      overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_reg;
`endif

  assign q_pop      = en && (state_reg == POP);
  assign en_a       = en && (state_reg == EVAL_A);
  assign en_b       = en && (state_reg == EVAL_B);
  assign win_rotate = en && (state_reg == EVAL_B) && (stage_reg == '0);
  assign busy       = (state_reg != IDLE);
  assign stage      = stage_reg;
  assign timer_b    = timer_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_eval_scheduler.sv
// Bench for eval_scheduler: directed vector table, hand sequences, random run vs. reference model.
// Second instance uses a period shorter than STAGES+1 so lost deadlines actually occur.
module tb_eval_scheduler;

  typedef struct {
    int unsigned ticks;
    bit          pend;
    bit          ovr;
    int unsigned ocnt;
    int          job;
    int          elapsed;
  } model_t;

  typedef struct {
    bit         en;
    bit         qv;
    int         timer;
    int         stage;
    logic [4:0] flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        q_pop_valid = 1'b0;

  logic        q_pop0, en_a0, en_b0, win_rotate0, busy0, overrun0;
  logic [3:0]  stage0;
  logic [15:0] timer_b0, oc0;
  logic        q_pop1, en_a1, en_b1, win_rotate1, busy1, overrun1;
  logic [3:0]  stage1;
  logic [15:0] timer_b1, oc1;
  logic [63:0] obs0, obs1;

  int checks = 0;
  int failures = 0;
  model_t m0, m1;
  vec_t vecs[$];

  always #5 clk = ~clk;

  eval_scheduler #(.PERIOD_CYCLES(10), .STAGES(3), .TIMER_W(16), .STAGE_W(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .q_pop_valid(q_pop_valid),
    .q_pop(q_pop0), .en_a(en_a0), .en_b(en_b0), .stage(stage0),
    .win_rotate(win_rotate0), .timer_b(timer_b0), .busy(busy0), .overrun(overrun0)
`ifdef SCHED_OVERRUN_CNT_EN
    , .overrun_cnt(oc0)
`endif
  );

  eval_scheduler #(.PERIOD_CYCLES(3), .STAGES(3), .TIMER_W(16), .STAGE_W(4)) u_ovr (
    .clk(clk), .rst(rst), .en(en), .q_pop_valid(q_pop_valid),
    .q_pop(q_pop1), .en_a(en_a1), .en_b(en_b1), .stage(stage1),
    .win_rotate(win_rotate1), .timer_b(timer_b1), .busy(busy1), .overrun(overrun1)
`ifdef SCHED_OVERRUN_CNT_EN
    , .overrun_cnt(oc1)
`endif
  );

`ifndef SCHED_OVERRUN_CNT_EN
  assign oc0 = 16'd0;
  assign oc1 = 16'd0;
`endif

  assign obs0 = {22'd0, timer_b0, stage0, q_pop0, en_a0, en_b0, win_rotate0, busy0, overrun0, oc0};
  assign obs1 = {22'd0, timer_b1, stage1, q_pop1, en_a1, en_b1, win_rotate1, busy1, overrun1, oc1};

  // Expected outputs derived from "which job runs and how far into it", not from FSM states.
  function automatic logic [63:0] model_out(model_t m, bit e, int p, int s);
    logic [15:0] t;
    logic [3:0]  st;
    logic [15:0] oc;
    bit qp, ea, eb, rot, bz;
    t  = 16'(m.ticks % p);
    st = 4'(s);
    qp = 0; ea = 0; eb = 0; rot = 0; bz = 0;
    if (m.job == 1) begin
      bz = 1;
      if (m.elapsed == 0) qp = e;
      else begin
        ea = e;
        st = 4'(m.elapsed - 1);
      end
    end else if (m.job == 2) begin
      bz  = 1;
      eb  = e;
      rot = e && (m.elapsed == 0);
      st  = 4'(m.elapsed);
    end
`ifdef SCHED_OVERRUN_CNT_EN
    oc = 16'(m.ocnt);
`else
    oc = 16'd0;
`endif
    return {22'd0, t, st, qp, ea, eb, rot, bz, m.ovr, oc};
  endfunction

  function automatic model_t model_step(model_t m, bit e, bit q, int p, int s);
    model_t n;
    bit dl, took;
    n = m;
    if (!e) return m;
    dl      = ((m.ticks % p) == p - 1);
    n.ticks = (m.ticks + 1) % p;
    took    = 0;
    if (m.job == 0) begin
      if (m.pend || dl) begin
        n.job = 2; n.elapsed = 0; took = 1;
      end else if (q) begin
        n.job = 1; n.elapsed = 0;
      end
    end else begin
      n.elapsed = m.elapsed + 1;
      if ((m.job == 1 && n.elapsed > s) || (m.job == 2 && n.elapsed >= s)) begin
        n.job = 0; n.elapsed = 0;
      end
    end
    if (took) n.pend = m.pend && dl;
    else if (dl) begin
      if (m.pend) begin
        n.ovr = 1;
        if (n.ocnt < 65535) n.ocnt = n.ocnt + 1;
      end
      n.pend = 1;
    end
    return n;
  endfunction

  function automatic vec_t mk(bit q, int t, int s, logic [4:0] f);
    vec_t v;
    v.en = 1; v.qv = q; v.timer = t; v.stage = s; v.flags = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit e, input bit q);
    en = e;
    q_pop_valid = q;
    @(negedge clk);
  endtask

  task automatic finish_cycle(input bit e, input bit q);
    chk("model_p10", obs0, model_out(m0, e, 10, 3));
    chk("model_p3", obs1, model_out(m1, e, 3, 3));
    m0 = model_step(m0, e, q, 10, 3);
    m1 = model_step(m1, e, q, 3, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(posedge clk);
    @(negedge clk);
    chk("reset_p10", obs0, {22'd0, 16'd0, 4'd3, 6'd0, 16'd0});
    chk("reset_p3", obs1, {22'd0, 16'd0, 4'd3, 6'd0, 16'd0});
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Columns: qv, timer_b, stage, {q_pop, en_a, en_b, win_rotate, busy}
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, i, 3, 5'b00000));
    vecs.push_back(mk(0, 0, 0, 5'b00111));
    vecs.push_back(mk(0, 1, 1, 5'b00101));
    vecs.push_back(mk(0, 2, 2, 5'b00101));
    vecs.push_back(mk(1, 3, 3, 5'b00000));
    vecs.push_back(mk(0, 4, 3, 5'b10001));
    vecs.push_back(mk(0, 5, 0, 5'b01001));
    vecs.push_back(mk(0, 6, 1, 5'b01001));
    vecs.push_back(mk(0, 7, 2, 5'b01001));
    vecs.push_back(mk(0, 8, 3, 5'b00000));
    vecs.push_back(mk(1, 9, 3, 5'b00000));
    vecs.push_back(mk(1, 0, 0, 5'b00111));
    vecs.push_back(mk(1, 1, 1, 5'b00101));
    vecs.push_back(mk(1, 2, 2, 5'b00101));
    vecs.push_back(mk(1, 3, 3, 5'b00000));
    vecs.push_back(mk(0, 4, 3, 5'b10001));
    vecs.push_back(mk(0, 5, 0, 5'b01001));
    vecs.push_back(mk(0, 6, 1, 5'b01001));
    vecs.push_back(mk(0, 7, 2, 5'b01001));
    vecs.push_back(mk(1, 8, 3, 5'b00000));
    vecs.push_back(mk(0, 9, 3, 5'b10001));
    vecs.push_back(mk(0, 0, 0, 5'b01001));
    vecs.push_back(mk(0, 1, 1, 5'b01001));
    vecs.push_back(mk(0, 2, 2, 5'b01001));
    vecs.push_back(mk(0, 3, 3, 5'b00000));
    vecs.push_back(mk(0, 4, 0, 5'b00111));
    vecs.push_back(mk(0, 5, 1, 5'b00101));
    vecs.push_back(mk(0, 6, 2, 5'b00101));
    vecs.push_back(mk(1, 7, 3, 5'b00000));

    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].qv);
      chk($sformatf("vec%0d", i), obs0,
          {22'd0, 16'(vecs[i].timer), 4'(vecs[i].stage), vecs[i].flags, 1'b0, 16'd0});
      $display("vec %0d: qv=%0d timer_b=%0d stage=%0d flags=%b", i, vecs[i].qv, timer_b0, stage0,
               {q_pop0, en_a0, en_b0, win_rotate0, busy0});
      finish_cycle(vecs[i].en, vecs[i].qv);
    end

    // POP then A stage 0; freeze at stage 1 for 5 cycles.
    drive(1, 0); finish_cycle(1, 0);
    drive(1, 0); finish_cycle(1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0);
      chk("freeze_state", {48'd0, timer_b0, stage0, en_a0, busy0, q_pop0, en_b0},
          {48'd0, 16'd0, 4'd1, 4'b0100});
      $display("freeze %0d: stage=%0d timer_b=%0d en_a=%0d", i, stage0, timer_b0, en_a0);
      finish_cycle(0, 0);
    end
    drive(1, 0);
    chk("resume_stage1", {48'd0, timer_b0, stage0, en_a0, busy0, q_pop0, en_b0},
        {48'd0, 16'd0, 4'd1, 4'b1100});
    finish_cycle(1, 0);
    drive(1, 0);
    chk("resume_stage2", {48'd0, timer_b0, stage0, en_a0, busy0, q_pop0, en_b0},
        {48'd0, 16'd1, 4'd2, 4'b1100});
    // Asynchronous reset in the middle of the evaluation.
    rst = 1'b0;
    #1;
    chk("async_reset", obs0, {22'd0, 16'd0, 4'd3, 6'd0, 16'd0});
    $display("async reset: stage=%0d timer_b=%0d busy=%0d", stage0, timer_b0, busy0);
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Continuous queue traffic: the short-period instance must lose deadlines.
    for (int i = 0; i < 30; i++) begin
      drive(1, 1);
      finish_cycle(1, 1);
    end
    chk("overrun_short_period", {63'd0, overrun1}, 64'd1);
    chk("no_overrun_p10", {63'd0, overrun0}, 64'd0);
    $display("continuous: overrun_p3=%0d overrun_p10=%0d cnt_p3=%0d", overrun1, overrun0, oc1);

    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 100; i++) begin
        bit e, q;
        e = ($urandom_range(0, 7) != 0);
        q = $urandom_range(0, 1) == 1;
        drive(e, q);
        finish_cycle(e, q);
      end
      $display("random block %0d: timer_b=%0d stage=%0d overrun_p3=%0d", blk, timer_b0, stage0, overrun1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
